frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Upstream neighbour of the output wrapper. Buffers incoming display frames in a small FIFO, then presents them one at a time.
- Each frame is a 42-bit pattern plus a 14-bit id/duration word. It is held on the outputs for its programmed duration, measured in prescaled ticks.
- bitsOut and idAndDurationOut connect directly to the output wrapper's bitsIn and idAndDurationIn.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TICK_DIV, 50000, clock cycles per duration tick; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- resetN  input  1  asynchronous active-low reset.
- frameValid  input  1  producer has a frame on frameBits and frameIdAndDuration.
- frameReady  output  1  FIFO can accept a frame this cycle.
- frameBits  input  42  pattern to display.
- frameIdAndDuration  input  14  [13:8] frame id (6 bits), [7:0] duration in ticks.
- enable  input  1  1 = run; 0 = pause the tick prescaler and hold all state.
- bitsOut  output  42  displayed pattern; feeds the output wrapper's bitsIn.
- idAndDurationOut  output  14  id/duration of the displayed frame; feeds the output wrapper's idAndDurationIn.
- active  output  1  a frame is currently being timed.
- frameDone  output  1  one-cycle pulse when the displayed frame's duration expires.

Behaviour:
- Reset, asynchronous, while resetN=0:
  - bitsOut=0, idAndDurationOut=0, active=0, frameDone=0.
  - FIFO empty, prescaler=0, remaining=0, state=IDLE.
  - frameReady=0 while reset is asserted; it rises the first cycle after release.
  - Reset mid-display discards all buffered and displayed frames.
- Input handshake:
  - frameReady = (count != DEPTH), taken from the registered count.
  - A push occurs on a rising edge where frameValid & frameReady; both data words are written together.
  - When the FIFO is full, frameReady=0, even if a pop happens in the same cycle.
  - The producer must hold data stable while frameValid=1 and frameReady=0.
- Simultaneous push and pop on a non-full FIFO: both take effect and count is unchanged.
- State machine:
  - IDLE, enable=1, FIFO non-empty:
    - pop the head; load bitsOut and idAndDurationOut.
    - remaining = duration, with duration 0 treated as 1.
    - prescaler=0, active=1, go to SHOW.
  - IDLE, otherwise: hold outputs; active=0.
  - SHOW, enable=0: freeze prescaler and remaining; outputs hold.
  - SHOW, enable=1, prescaler != TICK_DIV-1: prescaler increments.
  - SHOW, enable=1, prescaler == TICK_DIV-1 (this is a tick): prescaler returns to 0.
    - remaining > 1: remaining decrements.
    - remaining == 1: frameDone=1 for this one cycle. Then:
      - FIFO non-empty: pop and load the next frame in the same edge (back-to-back, no gap); stay in SHOW.
      - FIFO empty: go to IDLE with active=0; bitsOut and idAndDurationOut keep the last frame.
- Latency:
  - A frame pushed into an empty FIFO while IDLE with enable=1 appears on bitsOut one cycle after the accepting edge.
  - Display time = max(duration,1) × TICK_DIV enabled cycles, counted from the load edge to the load/expiry edge.
- Widths:
  - remaining is 8 bits.
  - prescaler is ceil(log2(TICK_DIV)) bits, minimum 1.
  - FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- enable only gates the sequencer. Pushes are accepted regardless of enable.

Test Plan (TICK_DIV=4, DEPTH=4):
- Reset check: assert resetN=0 mid-SHOW with 3 frames queued → outputs go to 0 immediately; after release, active=0 and frameReady=1.
- Single frame: push bits=42'h2AA_AAAA_AAAA, id=5, dur=3 → bitsOut updates 1 cycle after the accept and holds 12 cycles; frameDone pulses once; active drops; bitsOut retains 42'h2AA_AAAA_AAAA.
- Back-to-back: push A(dur=1), B(dur=2), C(dur=1) → A shows 4 cycles, B 8, C 4; no idle cycle between frames; exactly 3 frameDone pulses; ids appear in order.
- Full FIFO: enable=0, push 5 frames → frameReady=0 after the 4th accept and the 5th is stalled. Raise enable → 5th is accepted on the pop cycle+1, and order is preserved.
- Pause: dur=2, drop enable for 7 cycles mid-frame → frame lasts 8+7 cycles; no frameDone while paused.
- Zero duration: push dur=0 → displayed 4 cycles (treated as 1 tick); idAndDurationOut[7:0] still reads 0.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// Producer-to-sequencer frame handshake.
// Data must stay stable while frameValid=1 and frameReady=0.
interface frame_sequencer_if;
  logic        frameValid;
  logic        frameReady;
  logic [41:0] frameBits;
  logic [13:0] frameIdAndDuration;

  modport master (
    output frameValid,
    output frameBits,
    output frameIdAndDuration,
    input  frameReady
  );

  modport slave (
    input  frameValid,
    input  frameBits,
    input  frameIdAndDuration,
    output frameReady
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame FIFO plus display timer.
// Each frame is held on the outputs for max(duration,1) prescaled ticks.
module frame_sequencer #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic                clk,
  input  logic                resetN,
  frame_sequencer_if.slave    frm,
  input  logic                enable,
  output logic [41:0]         bitsOut,
  output logic [13:0]         idAndDurationOut,
  output logic                active,
  output logic                frameDone
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t stateQ;
  state_t stateD;

  logic [55:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          readyQ;

  logic [PW-1:0] prescaler;
  logic [7:0]    remaining;

  logic          push;
  logic          pop;
  logic          notEmpty;
  logic          tickHit;
  logic          expire;
  logic [55:0]   head;
  logic [7:0]    headDur;

  // readyQ keeps frameReady low while reset is held
  assign frm.frameReady = readyQ && (count != FULL_CNT);

  assign push     = frm.frameValid && frm.frameReady;
  assign notEmpty = (count != '0);
  assign head     = mem[rdPtr];
  assign headDur  = head[7:0];
  assign tickHit  = enable && (prescaler == TICK_LAST);
  assign expire   = (stateQ == SHOW) && tickHit
                 && (remaining == 8'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      readyQ <= 1'b0;
    end else begin
      readyQ <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {frm.frameBits, frm.frameIdAndDuration};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (enable && notEmpty) begin
          stateD = SHOW;
        end
      end
      SHOW: begin
        if (expire && !notEmpty) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    frameDone = 1'b0;
    active    = 1'b0;
    unique case (stateQ)
      IDLE: begin
        pop = enable && notEmpty;
      end
      SHOW: begin
        active    = 1'b1;
        frameDone = expire;
        pop       = expire && notEmpty;
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // A pop always loads the head, whether from IDLE or back-to-back
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bitsOut          <= '0;
      idAndDurationOut <= '0;
      prescaler        <= '0;
      remaining        <= '0;
    end else if (pop) begin
      bitsOut          <= head[55:14];
      idAndDurationOut <= head[13:0];
      prescaler        <= '0;
      remaining        <= (headDur == 8'd0) ? 8'd1 : headDur;
    end else if (stateQ == SHOW && enable) begin
      if (tickHit) begin
        prescaler <= '0;
        remaining <= remaining - 8'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with TICK_DIV=4, DEPTH=4.
// Outputs are sampled 1ns after each rising edge.
module tb_frame_sequencer;

  logic        clk;
  logic        resetN;
  logic        enable;
  logic [41:0] bitsOut;
  logic [13:0] idAndDurationOut;
  logic        active;
  logic        frameDone;

  int nAssert;
  int nFail;
  int k;
  int sawDone;

  frame_sequencer_if fif ();

  frame_sequencer #(
    .DEPTH    (4),
    .TICK_DIV (4)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .frm              (fif),
    .enable           (enable),
    .bitsOut          (bitsOut),
    .idAndDurationOut (idAndDurationOut),
    .active           (active),
    .frameDone        (frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [41:0] b,
                      input logic [5:0]  id,
                      input logic [7:0]  d);
    int n;
    fif.frameValid         = 1'b1;
    fif.frameBits          = b;
    fif.frameIdAndDuration = {id, d};
    n = 0;
    while (fif.frameReady !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", {63'd0, fif.frameReady}, 64'd1);
    tick();
    fif.frameValid = 1'b0;
  endtask

  task automatic waitDone(output int cnt);
    cnt = 0;
    while (frameDone !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    resetN  = 1'b0;
    enable  = 1'b0;
    fif.frameValid         = 1'b0;
    fif.frameBits          = '0;
    fif.frameIdAndDuration = '0;

    // reset state
    tick();
    tick();
    chk("rst_bits", {22'd0, bitsOut}, 64'd0);
    chk("rst_id", {50'd0, idAndDurationOut}, 64'd0);
    chk("rst_active", {63'd0, active}, 64'd0);
    chk("rst_done", {63'd0, frameDone}, 64'd0);
    chk("rst_ready", {63'd0, fif.frameReady}, 64'd0);
    resetN = 1'b1;
    tick();
    chk("rel_ready", {63'd0, fif.frameReady}, 64'd1);

    // single frame, dur=3 -> 12 cycles
    enable = 1'b1;
    push(42'h2AA_AAAA_AAAA, 6'd5, 8'd3);
    chk("s_pre_bits", {22'd0, bitsOut}, 64'd0);
    tick();
    chk("s_bits", {22'd0, bitsOut}, 64'h2AA_AAAA_AAAA);
    chk("s_id", {50'd0, idAndDurationOut}, 64'h503);
    chk("s_active", {63'd0, active}, 64'd1);
    waitDone(k);
    chk("s_len", 64'(k), 64'd11);
    tick();
    chk("s_done_off", {63'd0, frameDone}, 64'd0);
    chk("s_idle", {63'd0, active}, 64'd0);
    chk("s_keep", {22'd0, bitsOut}, 64'h2AA_AAAA_AAAA);

    // back-to-back A(1) B(2) C(1)
    enable = 1'b0;
    push(42'h111, 6'd1, 8'd1);
    push(42'h222, 6'd2, 8'd2);
    push(42'h333, 6'd3, 8'd1);
    enable = 1'b1;
    tick();
    chk("bb_a_bits", {22'd0, bitsOut}, 64'h111);
    chk("bb_a_id", {50'd0, idAndDurationOut}, 64'h101);
    waitDone(k);
    chk("bb_a_len", 64'(k), 64'd3);
    tick();
    chk("bb_b_id", {50'd0, idAndDurationOut}, 64'h202);
    chk("bb_b_active", {63'd0, active}, 64'd1);
    chk("bb_b_done", {63'd0, frameDone}, 64'd0);
    waitDone(k);
    chk("bb_b_len", 64'(k), 64'd7);
    tick();
    chk("bb_c_id", {50'd0, idAndDurationOut}, 64'h301);
    waitDone(k);
    chk("bb_c_len", 64'(k), 64'd3);
    tick();
    chk("bb_idle", {63'd0, active}, 64'd0);

    // full FIFO with enable low
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(42'(i * 37 + 1), 6'(10 + i), 8'd1);
    end
    chk("f_full", {63'd0, fif.frameReady}, 64'd0);
    fif.frameValid         = 1'b1;
    fif.frameBits          = 42'(4 * 37 + 1);
    fif.frameIdAndDuration = {6'd14, 8'd1};
    tick();
    tick();
    chk("f_stall", {63'd0, fif.frameReady}, 64'd0);
    chk("f_noact", {63'd0, active}, 64'd0);
    enable = 1'b1;
    tick();
    chk("f_f0_bits", {22'd0, bitsOut}, 64'd1);
    chk("f_ready", {63'd0, fif.frameReady}, 64'd1);
    tick();
    fif.frameValid = 1'b0;
    waitDone(k);
    chk("f_f0_len", 64'(k), 64'd2);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("f_order", {50'd0, idAndDurationOut},
          64'({6'(10 + i), 8'd1}));
      waitDone(k);
    end
    tick();
    chk("f_idle", {63'd0, active}, 64'd0);

    // pause mid-frame for 7 cycles
    push(42'h0F0F, 6'd7, 8'd2);
    tick();
    chk("p_id", {50'd0, idAndDurationOut}, 64'h702);
    tick();
    tick();
    tick();
    enable  = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 7; i++) begin
      if (frameDone !== 1'b0) sawDone++;
      tick();
    end
    chk("p_nodone", 64'(sawDone), 64'd0);
    chk("p_hold", {63'd0, active}, 64'd1);
    enable = 1'b1;
    waitDone(k);
    chk("p_len", 64'(k), 64'd4);
    tick();

    // zero duration shows one tick
    push(42'h3FF_0000_0001, 6'd9, 8'd0);
    tick();
    chk("z_id", {50'd0, idAndDurationOut}, 64'h900);
    waitDone(k);
    chk("z_len", 64'(k), 64'd3);
    tick();
    chk("z_idle", {63'd0, active}, 64'd0);

    // reset mid-show with 3 queued
    push(42'hA1, 6'd1, 8'd5);
    push(42'hA2, 6'd2, 8'd5);
    push(42'hA3, 6'd3, 8'd5);
    push(42'hA4, 6'd4, 8'd5);
    chk("r_show", {63'd0, active}, 64'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("r_bits", {22'd0, bitsOut}, 64'd0);
    chk("r_id", {50'd0, idAndDurationOut}, 64'd0);
    chk("r_active", {63'd0, active}, 64'd0);
    chk("r_ready", {63'd0, fif.frameReady}, 64'd0);
    tick();
    resetN = 1'b1;
    tick();
    chk("r_rel_ready", {63'd0, fif.frameReady}, 64'd1);
    chk("r_rel_act", {63'd0, active}, 64'd0);
    tick();
    tick();
    chk("r_flushed", {63'd0, active}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
